ads127l01_fsync_rx: RTL and testbench

Receiver for the ADS127L01 frame-sync serial interface with the ADC as interface master. It oversamples the ADC-driven `sck`, `dout` and `fsync` in the system `clk` domain and deserializes each 24-bit conversion result, MSB first. It then presents the result as a one-cycle `valid` strobe with parallel `data` to the downstream filter/DAQ logic. It also flags malformed frames.

---
 rtl/ads127l01_fsync_rx.sv | 158 +++++++++++++++
 tb/tb_ads127l01_fsync_rx.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/ads127l01_fsync_rx.sv
// ADS127L01 frame-sync serial receiver (ADC is interface master).
// Oversamples sck/dout/fsync in the clk domain and deserializes MSB-first words.
module ads127l01_fsync_rx #(
    parameter int unsigned DW          = 24,
    parameter int unsigned FRAME_SCK   = 32,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          en,
    input  logic          sck,
    input  logic          dout,
    input  logic          fsync,
    output logic [DW-1:0] data,
    output logic          valid,
    output logic          frame_err
);

    localparam int unsigned CW = $clog2(2 * FRAME_SCK) + 1;
    localparam int unsigned BW = $clog2(DW + 1);

    localparam logic [CW-1:0] CNT_MAX   = '1;
    localparam logic [CW-1:0] FRAME_LEN = CW'(FRAME_SCK);
    localparam logic [BW-1:0] WORD_BITS = BW'(DW);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_WAIT
    } state_t;

    logic [SYNC_STAGES-1:0] sck_sync_q;
    logic [SYNC_STAGES-1:0] dout_sync_q;
    logic [SYNC_STAGES-1:0] fsync_sync_q;
    logic                   sck_d_q;

    logic                   sck_s;
    logic                   dout_s;
    logic                   fsync_s;
    logic                   rise;
    logic                   fall;
    logic                   start;

    state_t                 state_q;
    logic                   fs_q;
    logic                   first_q;
    logic [BW-1:0]          bitcnt_q;
    logic [CW-1:0]          sckcnt_q;
    logic [CW-1:0]          sckcnt_d;
    logic [DW-1:0]          shreg_q;
    logic [DW-1:0]          data_q;
    logic                   valid_q;
    logic                   frame_err_q;

    // All three inputs share one synchronizer depth so their alignment survives.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sck_sync_q   <= '0;
            dout_sync_q  <= '0;
            fsync_sync_q <= '0;
            sck_d_q      <= 1'b0;
        end else begin
            sck_sync_q   <= SYNC_STAGES'({sck_sync_q, sck});
            dout_sync_q  <= SYNC_STAGES'({dout_sync_q, dout});
            fsync_sync_q <= SYNC_STAGES'({fsync_sync_q, fsync});
            sck_d_q      <= sck_s;
        end
    end

    assign sck_s   = sck_sync_q[SYNC_STAGES-1];
    assign dout_s  = dout_sync_q[SYNC_STAGES-1];
    assign fsync_s = fsync_sync_q[SYNC_STAGES-1];

    assign rise  = sck_s & ~sck_d_q;
    assign fall  = ~sck_s & sck_d_q;
    assign start = fall & fsync_s & ~fs_q;

    assign sckcnt_d = (sckcnt_q == CNT_MAX) ? sckcnt_q : sckcnt_q + 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            fs_q        <= 1'b0;
            first_q     <= 1'b1;
            bitcnt_q    <= '0;
            sckcnt_q    <= '0;
            shreg_q     <= '0;
            data_q      <= '0;
            valid_q     <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            valid_q     <= 1'b0;
            frame_err_q <= 1'b0;
            if (!en) begin
                state_q  <= ST_IDLE;
                fs_q     <= 1'b0;
                first_q  <= 1'b1;
                bitcnt_q <= '0;
                sckcnt_q <= '0;
            end else begin
                if (fall) begin
                    fs_q <= fsync_s;
                end
                case (state_q)
                    ST_IDLE: begin
                        if (start) begin
                            state_q  <= ST_SHIFT;
                            bitcnt_q <= '0;
                            sckcnt_q <= '0;
                            first_q  <= 1'b0;
                        end
                    end
                    ST_SHIFT: begin
                        // start outranks rise: a new frame mid-word discards the partial word
                        if (start) begin
                            frame_err_q <= 1'b1;
                            bitcnt_q    <= '0;
                            sckcnt_q    <= '0;
                            shreg_q     <= '0;
                        end else begin
                            if (rise) begin
                                sckcnt_q <= sckcnt_d;
                            end
                            if (bitcnt_q == WORD_BITS) begin
                                data_q  <= shreg_q;
                                valid_q <= 1'b1;
                                state_q <= ST_WAIT;
                            end else if (rise) begin
                                shreg_q  <= {shreg_q[DW-2:0], dout_s};
                                bitcnt_q <= bitcnt_q + 1'b1;
                            end
                        end
                    end
                    ST_WAIT: begin
                        if (start) begin
                            state_q  <= ST_SHIFT;
                            bitcnt_q <= '0;
                            sckcnt_q <= '0;
                            if (!first_q && (sckcnt_q != FRAME_LEN)) begin
                                frame_err_q <= 1'b1;
                            end
                        end else if (rise) begin
                            sckcnt_q <= sckcnt_d;
                        end
                    end
                    default: begin
                        state_q <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign data      = data_q;
    assign valid     = valid_q;
    assign frame_err = frame_err_q;

endmodule

// File: tb/tb_ads127l01_fsync_rx.sv
// Scoreboard bench for ads127l01_fsync_rx: frame-level reference model feeds an
// expected-event queue; a negedge monitor pops and compares every valid/frame_err.
module tb_ads127l01_fsync_rx;

    localparam int DW = 24;
    localparam int FS = 32;

    logic          clk   = 1'b0;
    logic          rst_n = 1'b0;
    logic          en    = 1'b1;
    logic          sck   = 1'b0;
    logic          dout  = 1'b0;
    logic          fsync = 1'b0;
    logic [DW-1:0] data;
    logic          valid;
    logic          frame_err;

    int cyc   = 0;
    int tests = 0;
    int fails = 0;

    typedef struct {
        bit            is_err;
        logic [DW-1:0] d;
        int            cyc;
    } exp_t;

    exp_t expq[$];
    int   vcycs[$];

    // Frame-level model state: a frame is "active" from its start until aborted.
    bit            m_active = 1'b0;
    bit            m_full   = 1'b0;
    int            m_len    = 0;
    logic [DW-1:0] m_data   = '0;

    ads127l01_fsync_rx #(
        .DW(DW),
        .FRAME_SCK(FS),
        .SYNC_STAGES(2)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .en(en),
        .sck(sck),
        .dout(dout),
        .fsync(fsync),
        .data(data),
        .valid(valid),
        .frame_err(frame_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic pop_check(input bit is_err, input logic [DW-1:0] d);
        exp_t e;
        tests++;
        if (expq.size() == 0) begin
            fails++;
            $display("FAIL event: unexpected %s data=%h at cyc %0d",
                     is_err ? "frame_err" : "valid", d, cyc);
        end else begin
            e = expq.pop_front();
            if (e.is_err != is_err || e.cyc != cyc || (!is_err && e.d !== d)) begin
                fails++;
                $display("FAIL event: got %s data=%h cyc=%0d, expected %s data=%h cyc=%0d",
                         is_err ? "frame_err" : "valid", d, cyc,
                         e.is_err ? "frame_err" : "valid", e.d, e.cyc);
            end
        end
        if (!is_err) vcycs.push_back(cyc);
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (valid === 1'b1) pop_check(1'b0, data);
            if (frame_err === 1'b1) pop_check(1'b1, '0);
        end
    end

    // One sck period is 8 clk: rise, 4 clk high, fall, 4 clk low.
    task automatic send_frame(input logic [DW-1:0] w, input int n, input int fs_hi,
                              input int en_off, input int en_on, input int rst_at);
        logic [DW-1:0] sh;
        for (int j = 0; j < n; j++) begin
            @(negedge clk);
            sck   = 1'b1;
            fsync = (j < fs_hi);
            if (j == en_off) begin
                en       = 1'b0;
                m_active = 1'b0;
            end
            if (j == en_on) en = 1'b1;
            if (j == rst_at) begin
                rst_n    = 1'b0;
                m_active = 1'b0;
                m_data   = '0;
                #1;
                check("rst_data", data, m_data);
                check("rst_valid", {23'd0, valid}, '0);
                check("rst_frame_err", {23'd0, frame_err}, '0);
            end
            if (rst_at >= 0 && j == rst_at + 1) rst_n = 1'b1;
            // The LSB is sampled on the 24th rise after start.
            if (j == DW && m_active) begin
                expq.push_back('{1'b0, w, cyc + 4});
                m_data = w;
                m_full = 1'b1;
            end
            repeat (4) @(negedge clk);
            sck = 1'b0;
            sh  = w << j;
            dout = (j < DW) ? sh[DW-1] : 1'($urandom);
            if (j == 0) begin
                if (m_active && (!m_full || m_len != FS))
                    expq.push_back('{1'b1, '0, cyc + 3});
                m_active = 1'b1;
                m_full   = 1'b0;
                m_len    = n;
            end
            repeat (3) @(negedge clk);
        end
    endtask

    task automatic idle(input int k);
        for (int j = 0; j < k; j++) begin
            @(negedge clk);
            sck   = 1'b1;
            fsync = 1'b0;
            repeat (4) @(negedge clk);
            sck  = 1'b0;
            dout = 1'($urandom);
            repeat (3) @(negedge clk);
        end
        m_len += k;
    endtask

    task automatic frame(input logic [DW-1:0] w, input int n, input int fs_hi);
        send_frame(w, n, fs_hi, -1, -1, -1);
    endtask

    initial begin
        int n;
        int r;
        int fh;

        repeat (3) @(negedge clk);
        check("reset_data", data, '0);
        check("reset_valid", {23'd0, valid}, '0);
        check("reset_frame_err", {23'd0, frame_err}, '0);
        rst_n = 1'b1;
        idle(2);

        // Single frame followed by back-to-back frames.
        vcycs.delete();
        frame(24'hA55AC3, 32, 15);
        frame(24'h800000, 32, 15);
        frame(24'h7FFFFF, 32, 15);
        frame(24'h000001, 32, 15);
        check_int("b2b_valid_count", vcycs.size(), 4);
        if (vcycs.size() == 4) begin
            for (int i = 0; i < 3; i++)
                check_int("b2b_spacing", vcycs[i+1] - vcycs[i], 256);
        end
        check("b2b_last_data", data, m_data);

        // Truncated frame: 10 data bits then a new fsync.
        frame(24'($urandom), 11, 5);
        frame(24'hC0FFEE, 32, 15);
        check("trunc_data", data, m_data);

        // Short frame spacing after a good frame.
        frame(24'($urandom), 30, 12);
        frame(24'($urandom), 32, 15);
        frame(24'($urandom), 32, 15);
        check("short_data", data, m_data);

        // Enable dropped during bit 12, raised again after fsync falls.
        send_frame(24'($urandom), 32, 15, 12, 20, -1);
        check("en_hold_data", data, m_data);
        frame(24'($urandom), 32, 15);
        frame(24'($urandom), 32, 15);
        check("en_resume_data", data, m_data);

        // Reset mid-frame, then a clean frame.
        send_frame(24'($urandom), 32, 15, -1, -1, 18);
        check("rst_hold_data", data, m_data);
        frame(24'h123456, 32, 15);
        check("rst_resume_data", data, m_data);

        // Long gap saturates the sck counter and must flag a length error.
        idle(120);
        frame(24'($urandom), 32, 15);

        for (int k = 0; k < 40; k++) begin
            r = $urandom_range(0, 9);
            if (r < 5)      n = 32;
            else if (r < 8) n = $urandom_range(25, 40);
            else            n = $urandom_range(2, 20);
            fh = (n - 1 < 15) ? n - 1 : 15;
            frame(24'($urandom), n, $urandom_range(1, fh));
            if (n > DW && $urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
        end
        check("random_final_data", data, m_data);

        idle(3);
        repeat (10) @(negedge clk);
        check_int("pending_events", expq.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
